// File: rtl/fetch_pkg.sv
// Shared types for the fetch sequencer: FSM states, redirect source encoding, default vectors.
package fetch_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    DROP = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_BR   = 2'd1,
    SEL_J    = 2'd2,
    SEL_JR   = 2'd3
  } redir_sel_t;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_EXC_PC   = 32'h0000_4180;

  function automatic logic [31:0] align_word(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/redirect_sel.sv
// Priority select of jr > j > br redirect targets (word-aligned) plus the
// pending-redirect register that holds a target until the next imem grant.
module redirect_sel
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_br_vld,
  input  logic [31:0] i_br_tgt,
  input  logic        i_j_vld,
  input  logic [31:0] i_j_tgt,
  input  logic        i_jr_vld,
  input  logic [31:0] i_jr_tgt,
  input  logic        i_pend_set,
  input  logic        i_pend_clr,
  output logic        o_redir_vld,
  output logic [31:0] o_redir_tgt,
  output logic        o_redir_mis,
  output logic        o_pend_vld,
  output logic [31:0] o_pend_tgt
);

  redir_sel_t  w_sel;
  logic [31:0] w_raw;
  logic        r_pend_vld;
  logic [31:0] r_pend_tgt;

  always_comb begin
    w_sel = SEL_NONE;
    w_raw = '0;
    if (i_jr_vld) begin
      w_sel = SEL_JR;
      w_raw = i_jr_tgt;
    end else if (i_j_vld) begin
      w_sel = SEL_J;
      w_raw = i_j_tgt;
    end else if (i_br_vld) begin
      w_sel = SEL_BR;
      w_raw = i_br_tgt;
    end
  end

  assign o_redir_vld = (w_sel != SEL_NONE);
  assign o_redir_tgt = align_word(w_raw);
  assign o_redir_mis = o_redir_vld && (w_raw[1:0] != 2'b00);

  // A newer redirect simply overwrites an older pending one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend_vld <= 1'b0;
      r_pend_tgt <= '0;
    end else if (i_pend_clr) begin
      r_pend_vld <= 1'b0;
    end else if (i_pend_set) begin
      r_pend_vld <= 1'b1;
      r_pend_tgt <= o_redir_tgt;
    end
  end

  assign o_pend_vld = r_pend_vld;
  assign o_pend_tgt = r_pend_tgt;

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Fetch PC sequencer: one outstanding imem request, delay-slot redirects, output buffer + skid.
// Optional exception vectoring (exc_i, DROP state) is compiled in with `define EXC_EN.
module fetch_seq_ctrl
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC
`ifdef EXC_EN
  , parameter logic [31:0] EXC_PC = DEF_EXC_PC
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        j_valid_i,
  input  logic [31:0] j_target_i,
  input  logic        jr_valid_i,
  input  logic [31:0] jr_target_i,
`ifdef EXC_EN
  input  logic        exc_i,
`endif
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  output logic [31:0] pc_o,
  output logic        misalign_o
);

  state_t      r_state, w_next;
  logic [31:0] r_pc, w_pc_nxt, r_req_pc, r_instr, r_instr_pc, r_skid;
  logic        r_instr_vld, r_misalign;
  logic        w_redir_vld, w_redir_mis, w_pend_vld, w_pend_set, w_pend_clr;
  logic [31:0] w_redir_tgt, w_pend_tgt;
  logic        w_grant, w_rx_load, w_skid_park, w_skid_load, w_consume, w_exc;

`ifdef EXC_EN
  assign w_exc = exc_i;
`else
  assign w_exc = 1'b0;
`endif

  assign w_grant     = (r_state == REQ) && imem_gnt_i;
  assign w_consume   = r_instr_vld && !stall_i;
  assign w_rx_load   = (r_state == WAIT) && imem_rvalid_i && (!r_instr_vld || !stall_i);
  assign w_skid_park = (r_state == WAIT) && imem_rvalid_i && r_instr_vld && stall_i;
  assign w_skid_load = (r_state == HOLD) && !stall_i;
  // While a request sits on the bus its address must not move, so the target waits for the grant.
  assign w_pend_set  = (r_state == REQ) && !imem_gnt_i && w_redir_vld && !w_exc;
  assign w_pend_clr  = w_grant || w_exc;

  redirect_sel u_redirect_sel (
    .clk         (clk),
    .reset       (reset),
    .i_br_vld    (br_taken_i),
    .i_br_tgt    (br_target_i),
    .i_j_vld     (j_valid_i),
    .i_j_tgt     (j_target_i),
    .i_jr_vld    (jr_valid_i),
    .i_jr_tgt    (jr_target_i),
    .i_pend_set  (w_pend_set),
    .i_pend_clr  (w_pend_clr),
    .o_redir_vld (w_redir_vld),
    .o_redir_tgt (w_redir_tgt),
    .o_redir_mis (w_redir_mis),
    .o_pend_vld  (w_pend_vld),
    .o_pend_tgt  (w_pend_tgt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: w_next = REQ;
      REQ:  if (imem_gnt_i) w_next = WAIT;
      WAIT: if (imem_rvalid_i) w_next = (!r_instr_vld || !stall_i) ? REQ : HOLD;
      HOLD: if (!stall_i) w_next = REQ;
`ifdef EXC_EN
      DROP: if (imem_rvalid_i) w_next = REQ;
`endif
      default: w_next = IDLE;
    endcase
`ifdef EXC_EN
    if (w_exc) begin
      case (r_state)
        REQ:        w_next = imem_gnt_i ? DROP : REQ;
        WAIT, DROP: w_next = imem_rvalid_i ? REQ : DROP;
        default:    w_next = REQ;
      endcase
    end
`endif
  end

  always_comb begin
    imem_req_o = (r_state == REQ);
  end

  always_comb begin
    w_pc_nxt = r_pc;
    if (w_grant)
      w_pc_nxt = w_redir_vld ? w_redir_tgt : (w_pend_vld ? w_pend_tgt : r_pc + 32'd4);
    else if (w_redir_vld && (r_state != REQ))
      w_pc_nxt = w_redir_tgt;
`ifdef EXC_EN
    if (w_exc) w_pc_nxt = EXC_PC;
`endif
  end

  // The skid word always belongs to r_req_pc: no grant can happen while HOLD is occupied.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc        <= RESET_PC;
      r_req_pc    <= '0;
      r_instr     <= '0;
      r_instr_pc  <= '0;
      r_instr_vld <= 1'b0;
      r_skid      <= '0;
      r_misalign  <= 1'b0;
    end else begin
      r_pc       <= w_pc_nxt;
      r_misalign <= w_redir_mis;
      if (w_grant) r_req_pc <= r_pc;
      if (w_skid_park) r_skid <= imem_rdata_i;
      if (w_exc) begin
        r_instr_vld <= 1'b0;
      end else if (w_rx_load) begin
        r_instr     <= imem_rdata_i;
        r_instr_pc  <= r_req_pc;
        r_instr_vld <= 1'b1;
      end else if (w_skid_load) begin
        r_instr     <= r_skid;
        r_instr_pc  <= r_req_pc;
        r_instr_vld <= 1'b1;
      end else if (w_consume) begin
        r_instr_vld <= 1'b0;
      end
    end
  end

  assign imem_addr_o   = r_pc;
  assign pc_o          = r_pc;
  assign instr_valid_o = r_instr_vld;
  assign instr_o       = r_instr;
  assign instr_pc_o    = r_instr_pc;
  assign misalign_o    = r_misalign;

endmodule
